spi_ram_ctrl: RTL

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_pkg.sv | 17 +
 rtl/spi_ram_ctrl_if.sv | 22 ++
 rtl/spi_ram_array.sv | 34 +++
 rtl/spi_ram_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Opcodes and arming-state encodings shared by the SPI slave and the RAM controller.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [0:0] ST_UNARMED = 1'b0;
  localparam logic [0:0] ST_ARMED   = 1'b1;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI slave (master side) and the RAM controller.
interface spi_ram_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           din;
  logic                 rx_valid;
  logic [7:0]           dout;
  logic                 tx_valid;
  logic                 err;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  modport master (
    output din, rx_valid,
    input  dout, tx_valid, err, wr_addr, rd_addr
  );

  modport slave (
    input  din, rx_valid,
    output dout, tx_valid, err, wr_addr, rd_addr
  );
endinterface

// File: rtl/spi_ram_array.sv
// Single-port byte RAM: one write or one read per cycle, registered read data.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  // Storage is never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register only loads on a read, so it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command words into RAM accesses with independent, self-incrementing
// write and read pointers; data commands are rejected until their pointer is loaded.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_ram_ctrl_if.slave bus
);
  cmd_t                 cmd;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [0:0]           wr_state_q, wr_state_d;
  logic [0:0]           rd_state_q, rd_state_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we, mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           rd_data;

  assign cmd      = cmd_t'(bus.din);
  assign cmd_addr = ADDR_SIZE'(cmd.payload);

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = rd_addr_q;
    if (bus.rx_valid) begin
      unique case (cmd.op)
        OP_WR_ADDR: begin
          wr_addr_d  = cmd_addr;
          wr_state_d = ST_ARMED;
        end
        OP_WR_DATA: begin
          if (wr_state_q == ST_ARMED) begin
            mem_we    = 1'b1;
            mem_addr  = wr_addr_q;
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d  = cmd_addr;
          rd_state_d = ST_ARMED;
        end
        default: begin
          // Read data appears from the array's output register one cycle later,
          // lining up with the registered tx_valid pulse.
          if (rd_state_q == ST_ARMED) begin
            mem_re     = 1'b1;
            rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
            tx_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_state_q <= ST_UNARMED;
      rd_state_q <= ST_UNARMED;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  spi_ram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (cmd.payload),
    .rdata (rd_data)
  );

  assign bus.dout     = rd_data;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.rd_addr  = rd_addr_q;
endmodule
